// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous imem addressing, one-entry stall hold buffer, redirect squash.
// Define FETCH_PERF_EN to add the perf_fetched / perf_squashed counters.
module fetch_unit #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_q,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [4:0]        inst_opcode,
    output logic [ADDR_W-1:0] inst_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_squashed,
`endif
    output logic [ADDR_W-1:0] inst_pc_plus1
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              hold_valid_q, hold_valid_d;
    logic [31:0]       hold_inst_q, hold_inst_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;

    // The hold entry, when present, always shadows the live imem word.
    assign imem_addr     = pc_q;
    assign inst_valid    = hold_valid_q | req_valid_q;
    assign inst          = hold_valid_q ? hold_inst_q : imem_q;
    assign inst_pc       = hold_valid_q ? hold_pc_q : req_pc_q;
    assign inst_opcode   = inst[31:27];
    assign inst_pc_plus1 = inst_pc + 1'b1;

    always_comb begin
        pc_d         = pc_q;
        req_valid_d  = req_valid_q;
        req_pc_d     = req_pc_q;
        hold_valid_d = hold_valid_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        if (redirect) begin
            pc_d         = redirect_pc;
            req_valid_d  = 1'b0;
            hold_valid_d = 1'b0;
        end else if (stall) begin
            req_valid_d = 1'b0;
            if (req_valid_q && !hold_valid_q) begin
                hold_valid_d = 1'b1;
                hold_inst_d  = imem_q;
                hold_pc_d    = req_pc_q;
            end
        end else begin
            hold_valid_d = 1'b0;
            req_valid_d  = 1'b1;
            req_pc_d     = pc_q;
            pc_d         = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= '0;
            req_valid_q  <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            req_valid_q  <= req_valid_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Payload registers need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clock) begin
        req_pc_q    <= req_pc_d;
        hold_inst_q <= hold_inst_d;
        hold_pc_q   <= hold_pc_d;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;

    always_comb begin
        perf_fetched_d  = perf_fetched_q;
        perf_squashed_d = perf_squashed_q;
        if (redirect && inst_valid)
            perf_squashed_d = perf_squashed_q + 32'd1;
        else if (!redirect && !stall && inst_valid)
            perf_fetched_d = perf_fetched_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule
